// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single-ported memory,
// with a memory-dump request path. One memory operation is in flight at a time. A request
// sampled in IDLE is accessed in the next cycle and acknowledged in the cycle after that.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous requests by
// round-robin. When it is undefined, port 1 (data) always wins a tie.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pN_req/wr/addr/wdata     per-port request, write flag, word address, write data
//   pN_ack/err/rdata         per-port completion pulse, out-of-range flag, read data
//   dump_req / dump_done     memory-dump request and its completion pulse
//   mem_en/wr/addr/wdata     memory access controls
//   mem_dump                 memory dump strobe
//   mem_rdata                combinational read data from the memory
module mem_arbiter #(
    parameter int unsigned MEM_AW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    input  logic        dump_req,
    output logic        dump_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic        mem_dump,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StAccess, StResp, StDump, StDresp} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;       // granted port: 0 = fetch, 1 = data
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        in_range;
    logic        tie_p1;
    logic        sel_p1;
    logic [31:0] rd_val;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        rr_q, rr_d;         // most recently granted port
    assign tie_p1 = ~rr_q;
`else
    assign tie_p1 = 1'b1;
`endif

    // Any set bit at or above MEM_AW makes the address out of range.
    assign in_range = ((addr_q >> MEM_AW) == 32'd0);
    assign sel_p1   = p1_req & (~p0_req | tie_p1);

    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        rd_val    = 32'd0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        dump_done = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_dump  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (dump_req) begin
                    state_d = StDump;
                end else if (p0_req || p1_req) begin
                    gnt_d   = sel_p1;
                    wr_d    = sel_p1 ? p1_wr    : p0_wr;
                    addr_d  = sel_p1 ? p1_addr  : p0_addr;
                    wdata_d = sel_p1 ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_d    = sel_p1;
`endif
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (in_range) begin
                    mem_en    = 1'b1;
                    mem_wr    = wr_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
                err_d  = ~in_range;
                // Reads and errors update the granted port's rdata; in-range writes keep it.
                rd_val = in_range ? mem_rdata : 32'd0;
                if (!in_range || !wr_q) begin
                    if (gnt_q) rdata1_d = rd_val;
                    else       rdata0_d = rd_val;
                end
                state_d = StResp;
            end
            StResp: begin
                p0_ack  = ~gnt_q;
                p1_ack  = gnt_q;
                p0_err  = ~gnt_q & err_q;
                p1_err  = gnt_q & err_q;
                state_d = StIdle;
            end
            StDump: begin
                mem_dump = 1'b1;
                state_d  = StDresp;
            end
            StDresp: begin
                dump_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q     <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences
// (tie order, dump contention, reset aborts) and a randomized phase checked against a
// transaction-level reference model (port rdata values, last-granted port, word memory).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_wr, p1_req, p1_wr;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        dump_req, dump_done;
    logic        mem_en, mem_wr, mem_dump;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .dump_req(dump_req), .dump_done(dump_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_dump(mem_dump),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory device: 1024 words, combinational read, write at the clock edge.
    logic [31:0] mem_dev [0:1023];
    assign mem_rdata = mem_dev[mem_addr[9:0]];
    always @(posedge clk) if (mem_en && mem_wr) mem_dev[mem_addr[9:0]] <= mem_wdata;

    // Reference model state.
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] m_rd [2];
    bit          m_last;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rd[0] = 32'd0;
        m_rd[1] = 32'd0;
        m_last  = 1'b1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " p0_ack"}, 32'(p0_ack), 32'd0);
        chk({name, " p1_ack"}, 32'(p1_ack), 32'd0);
        chk({name, " dump_done"}, 32'(dump_done), 32'd0);
        chk({name, " mem_en"}, 32'(mem_en), 32'd0);
        chk({name, " mem_dump"}, 32'(mem_dump), 32'd0);
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after the ack. Inputs left as driven.
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input bit scramble,
                           output logic [31:0] got_rd, output bit got_err, output bit got_p1);
        bit          w, wr, inr;
        logic [31:0] a, d;
        p0_req = r0; p1_req = r1; p0_wr = w0; p1_wr = w1;
        p0_addr = a0; p1_addr = a1; p0_wdata = d0; p1_wdata = d1;
        dump_req = 1'b0;
        if (r0 && !r1)      w = 1'b0;
        else if (r1 && !r0) w = 1'b1;
        else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = ~m_last;
`else
            w = 1'b1;
`endif
        end
        m_last = w;
        wr  = w ? w1 : w0;
        a   = w ? a1 : a0;
        d   = w ? d1 : d0;
        inr = (a >> 16) == 32'd0;
        tick();  // access cycle
        if (scramble) begin
            p0_addr = $urandom; p1_addr = $urandom; p0_wdata = $urandom; p1_wdata = $urandom;
            p0_wr = 1'($urandom); p1_wr = 1'($urandom);
            #1;
        end
        chk("acc mem_en", 32'(mem_en), 32'(inr));
        chk("acc mem_dump", 32'(mem_dump), 32'd0);
        chk("acc acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        if (inr) begin
            chk("acc mem_wr", 32'(mem_wr), 32'(wr));
            chk("acc mem_addr", mem_addr, a);
            chk("acc mem_wdata", mem_wdata, d);
        end
        if (!inr)    m_rd[w] = 32'd0;
        else if (wr) ref_mem[a] = d;
        else         m_rd[w] = ref_read(a);
        tick();  // response cycle
        chk("resp p0_ack", 32'(p0_ack), 32'(!w));
        chk("resp p1_ack", 32'(p1_ack), 32'(w));
        chk("resp p0_err", 32'(p0_err), 32'(!w && !inr));
        chk("resp p1_err", 32'(p1_err), 32'(w && !inr));
        chk("resp p0_rdata", p0_rdata, m_rd[0]);
        chk("resp p1_rdata", p1_rdata, m_rd[1]);
        chk("resp mem_en", 32'(mem_en), 32'd0);
        got_rd  = w ? p1_rdata : p0_rdata;
        got_err = w ? p1_err : p0_err;
        got_p1  = p1_ack;
        tick();  // back to idle
        chk_quiet("idle");
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after dump_done.
    task automatic run_dump(input bit r0, input bit r1);
        p0_req = r0; p1_req = r1; dump_req = 1'b1;
        tick();
        chk("dump mem_dump", 32'(mem_dump), 32'd1);
        chk("dump mem_en", 32'(mem_en), 32'd0);
        chk("dump dump_done", 32'(dump_done), 32'd0);
        chk("dump acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        dump_req = 1'b0;
        tick();
        chk("dresp dump_done", 32'(dump_done), 32'd1);
        chk("dresp mem_dump", 32'(mem_dump), 32'd0);
        chk("dresp mem_en", 32'(mem_en), 32'd0);
        tick();
        chk_quiet("post-dump");
    endtask

    task automatic chk_all_zero(input string name);
        chk_quiet(name);
        chk({name, " errs"}, {30'd0, p1_err, p0_err}, 32'd0);
        chk({name, " mem_wr"}, 32'(mem_wr), 32'd0);
        chk({name, " mem_addr"}, mem_addr, 32'd0);
        chk({name, " mem_wdata"}, mem_wdata, 32'd0);
        chk({name, " p0_rdata"}, p0_rdata, 32'd0);
        chk({name, " p1_rdata"}, p1_rdata, 32'd0);
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } tv_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tv_t         tv [9];
        logic [31:0] rd;
        bit          er, g1;
        bit          tie_exp [4];

        tv[0] = '{1'b0, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
        tv[1] = '{1'b1, 1'b1, 32'h20,        32'h12345678, 32'h0,        1'b0};
        tv[2] = '{1'b1, 1'b0, 32'h20,        32'h0,        32'h12345678, 1'b0};
        tv[3] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,        32'h0,        1'b1};
        tv[4] = '{1'b0, 1'b1, 32'h30,        32'hAAAA5555, 32'h0,        1'b0};
        tv[5] = '{1'b0, 1'b0, 32'h30,        32'h0,        32'hAAAA5555, 1'b0};
        tv[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b1};
        tv[7] = '{1'b1, 1'b1, 32'h20,        32'hCAFEF00D, 32'h0,        1'b0};
        tv[8] = '{1'b0, 1'b0, 32'h20,        32'h0,        32'hCAFEF00D, 1'b0};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        tie_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        for (int i = 0; i < 1024; i++) mem_dev[i] = init_word(32'(i));
        mem_dev[16] = 32'hDEADBEEF;
        ref_mem[32'h10] = 32'hDEADBEEF;

        rst = 1'b0; dump_req = 1'b0;
        p0_req = 1'b0; p0_wr = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_req = 1'b0; p1_wr = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
        model_reset();
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_txn(!tv[i].port, tv[i].port, tv[i].wr, tv[i].wr, tv[i].addr, tv[i].addr,
                    tv[i].wdata, tv[i].wdata, 1'b0, rd, er, g1);
            chk($sformatf("tv%0d rdata", i), rd, tv[i].exp_rdata);
            chk($sformatf("tv%0d err", i), 32'(er), 32'(tv[i].exp_err));
        end
        p0_req = 1'b0; p1_req = 1'b0;

        // Reset during an access: no ack, everything cleared, pointer back to reset value.
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'h40;
        tick();
        chk("abort mem_en", 32'(mem_en), 32'd1);
        rst = 1'b0; p0_req = 1'b0;
        tick();
        model_reset();
        chk_all_zero("abort");
        rst = 1'b1;
        tick();
        chk_quiet("abort idle");

        // Tie held for four grants.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h60, 32'h0, 32'h0, 1'b0, rd, er, g1);
            chk($sformatf("tie grant %0d", i), 32'(g1), 32'(tie_exp[i]));
        end

        // Dump contending with both ports, then arbitration resumes.
        run_dump(1'b1, 1'b1);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h70, 32'h74, 32'h11, 32'h22, 1'b0, rd, er, g1);
        p0_req = 1'b0; p1_req = 1'b0;

        // Reset during a dump: no dump_done.
        dump_req = 1'b1;
        tick();
        chk("dabort mem_dump", 32'(mem_dump), 32'd1);
        rst = 1'b0; dump_req = 1'b0;
        tick();
        model_reset();
        chk_all_zero("dabort");
        rst = 1'b1;
        tick();
        chk_quiet("dabort idle");

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int unsigned op;
            logic [31:0] a0, a1;
            op = $urandom_range(0, 9);
            a0 = ($urandom_range(0, 3) == 0) ? ($urandom | (32'h1 << $urandom_range(16, 31)))
                                             : 32'($urandom_range(0, 1023));
            a1 = ($urandom_range(0, 3) == 0) ? ($urandom | (32'h1 << $urandom_range(16, 31)))
                                             : 32'($urandom_range(0, 1023));
            if (op == 0) begin
                run_dump(1'b0, 1'b0);
            end else begin
                run_txn(op <= 6, op == 1 || op >= 7, 1'($urandom), 1'($urandom), a0, a1,
                        $urandom, $urandom, 1'b1, rd, er, g1);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
